// File: rtl/combi_resp_checker_if.sv
// rtl/combi_resp_checker_if.sv - stimulus/response bundle between the checker and its client.
// Carries resp_vec only when COMBI_CHK_CAPTURE_EN is defined.
interface combi_resp_checker_if #(
  parameter int N_IN = 3
);
  logic                   start;
  logic [N_IN-1:0]        stim;
  logic                   y;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic [N_IN:0]          err_count;
  logic                   first_fail_valid;
  logic [N_IN-1:0]        first_fail_vec;
`ifdef COMBI_CHK_CAPTURE_EN
  logic [(1<<N_IN)-1:0]   resp_vec;
`endif

  modport master (
    input  start, y,
    output stim, busy, done, pass, err_count, first_fail_valid, first_fail_vec
`ifdef COMBI_CHK_CAPTURE_EN
    , output resp_vec
`endif
  );

  modport slave (
    output start, y,
    input  stim, busy, done, pass, err_count, first_fail_valid, first_fail_vec
`ifdef COMBI_CHK_CAPTURE_EN
    , input resp_vec
`endif
  );
endinterface

// File: rtl/combi_resp_checker.sv
// rtl/combi_resp_checker.sv - exhaustive stimulus walker and truth-table checker for 1-output cells.
// Optional COMBI_CHK_CAPTURE_EN records the measured truth table in resp_vec.
module combi_resp_checker #(
  parameter int                   N_IN        = 3,
  parameter int                   HOLD_CYCLES = 2,
  parameter logic [(1<<N_IN)-1:0] EXPECTED    = 8'hE8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  combi_resp_checker_if.master bus
);
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  localparam logic [N_IN-1:0] STIM_MAX  = {N_IN{1'b1}};
  localparam logic [7:0]      HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t          state, state_nxt;
  logic [7:0]      hold_cnt;
  logic [N_IN-1:0] stim_r;
  logic [N_IN:0]   err_count_r;
  logic [N_IN:0]   err_nxt;
  logic            pass_r;
  logic            ff_valid_r;
  logic [N_IN-1:0] ff_vec_r;
  logic            sample;
  logic            last_vec;
  logic            mismatch;
`ifdef COMBI_CHK_CAPTURE_EN
  logic [(1<<N_IN)-1:0] resp_vec_r;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sample    = 1'b0;
    last_vec  = (stim_r == STIM_MAX);
    mismatch  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) state_nxt = RUN;
      end
      RUN: begin
        sample   = (hold_cnt == HOLD_LAST);
        mismatch = sample && (bus.y != EXPECTED[stim_r]);
        if (sample && last_vec) state_nxt = FINISH;
      end
      FINISH: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    err_nxt = err_count_r + {{N_IN{1'b0}}, mismatch};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt    <= '0;
      stim_r      <= '0;
      err_count_r <= '0;
      pass_r      <= 1'b0;
      ff_valid_r  <= 1'b0;
      ff_vec_r    <= '0;
`ifdef COMBI_CHK_CAPTURE_EN
      resp_vec_r  <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            hold_cnt    <= '0;
            stim_r      <= '0;
            err_count_r <= '0;
            pass_r      <= 1'b0;
            ff_valid_r  <= 1'b0;
            ff_vec_r    <= '0;
`ifdef COMBI_CHK_CAPTURE_EN
            resp_vec_r  <= '0;
`endif
          end
        end
        RUN: begin
          if (sample) begin
            hold_cnt    <= '0;
            err_count_r <= err_nxt;
            if (mismatch && !ff_valid_r) begin
              ff_valid_r <= 1'b1;
              ff_vec_r   <= stim_r;
            end
`ifdef COMBI_CHK_CAPTURE_EN
            resp_vec_r[stim_r] <= bus.y;
`endif
            // pass must already be valid during the FINISH (done) cycle
            if (last_vec) begin
              pass_r <= (err_nxt == '0);
            end else begin
              stim_r <= stim_r + 1'b1;
            end
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        FINISH: begin
          stim_r <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.stim             = stim_r;
  assign bus.busy             = (state == RUN);
  assign bus.done             = (state == FINISH);
  assign bus.pass             = pass_r;
  assign bus.err_count        = err_count_r;
  assign bus.first_fail_valid = ff_valid_r;
  assign bus.first_fail_vec   = ff_vec_r;
`ifdef COMBI_CHK_CAPTURE_EN
  assign bus.resp_vec         = resp_vec_r;
`endif
endmodule

// File: tb/tb_combi_resp_checker.sv
// tb/tb_combi_resp_checker.sv - scoreboard bench for combi_resp_checker (HOLD_CYCLES 2 and 1 instances).
// resp_vec checks are active when COMBI_CHK_CAPTURE_EN is defined.
module tb_combi_resp_checker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int mode0 = 0;
  int mode1 = 0;
  int n_checks = 0;
  int n_fails = 0;

  typedef struct {
    int         err;
    int         ffv;
    int         ffvec;
    int         pass;
    int         busy_len;
    logic [7:0] resp;
  } exp_t;

  exp_t sb[$];

  combi_resp_checker_if #(.N_IN(3)) bus0();
  combi_resp_checker_if #(.N_IN(3)) bus1();

  function automatic logic maj3(logic [2:0] v);
    return (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
  endfunction

  // Modes: 0 correct majority, 1 stuck-at-0, 2 stuck-at-1, 3 wrong only at vector 7
  function automatic logic y_model(int mode, logic [2:0] v);
    case (mode)
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return (v == 3'd7) ? ~maj3(v) : maj3(v);
      default: return maj3(v);
    endcase
  endfunction

  function automatic exp_t model(int mode, int hold);
    exp_t e;
    e.err = 0; e.ffv = 0; e.ffvec = 0; e.resp = 8'h00;
    for (int i = 0; i < 8; i++) begin
      logic yv;
      yv = y_model(mode, 3'(i));
      e.resp[i] = yv;
      if (yv != maj3(3'(i))) begin
        if (e.ffv == 0) begin
          e.ffv   = 1;
          e.ffvec = i;
        end
        e.err++;
      end
    end
    e.pass     = (e.err == 0) ? 1 : 0;
    e.busy_len = 8 * hold;
    return e;
  endfunction

  assign bus0.y = y_model(mode0, bus0.stim);
  assign bus1.y = y_model(mode1, bus1.stim);

  combi_resp_checker #(.N_IN(3), .HOLD_CYCLES(2), .EXPECTED(8'hE8)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.master)
  );

  combi_resp_checker #(.N_IN(3), .HOLD_CYCLES(1), .EXPECTED(8'hE8)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.master)
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_zero0(string tag);
    check({tag, "_stim"}, 32'(bus0.stim), 32'd0);
    check({tag, "_busy"}, 32'(bus0.busy), 32'd0);
    check({tag, "_done"}, 32'(bus0.done), 32'd0);
    check({tag, "_pass"}, 32'(bus0.pass), 32'd0);
    check({tag, "_err"}, 32'(bus0.err_count), 32'd0);
    check({tag, "_ffv"}, 32'(bus0.first_fail_valid), 32'd0);
    check({tag, "_ffvec"}, 32'(bus0.first_fail_vec), 32'd0);
`ifdef COMBI_CHK_CAPTURE_EN
    check({tag, "_resp"}, 32'(bus0.resp_vec), 32'd0);
`endif
  endtask

  task automatic run0(int mode, bit repulse, bit abort);
    int   busy_n = 0;
    bit   got_done = 0;
    bit   pulsed = 0;
    exp_t e;
    mode0 = mode;
    if (!abort) sb.push_back(model(mode, 2));
    @(negedge clk) bus0.start = 1'b1;
    @(negedge clk) bus0.start = 1'b0;
    for (int c = 0; c < 100 && !got_done; c++) begin
      bus0.start = 1'b0;
      if (bus0.busy) begin
        check("stim_seq0", 32'(bus0.stim), 32'(busy_n / 2));
        busy_n++;
        if (repulse && !pulsed && bus0.stim == 3'd4) begin
          bus0.start = 1'b1;
          pulsed = 1;
        end
        if (abort && bus0.stim == 3'd5) begin
          int dones = 0;
          rst_n = 1'b0;
          @(negedge clk);
          rst_n = 1'b1;
          check_zero0("abort");
          for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (bus0.done) dones++;
          end
          check("abort_no_done", 32'(dones), 32'd0);
          return;
        end
      end else if (bus0.done) begin
        got_done = 1;
        if (sb.size() == 0) begin
          check("sb_empty0", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("busy_len0", 32'(busy_n), 32'(e.busy_len));
          check("err_count0", 32'(bus0.err_count), 32'(e.err));
          check("ff_valid0", 32'(bus0.first_fail_valid), 32'(e.ffv));
          check("ff_vec0", 32'(bus0.first_fail_vec), 32'(e.ffvec));
          check("pass0", 32'(bus0.pass), 32'(e.pass));
`ifdef COMBI_CHK_CAPTURE_EN
          check("resp_vec0", 32'(bus0.resp_vec), 32'(e.resp));
`endif
        end
      end
      if (!got_done) @(negedge clk);
    end
    if (!got_done) begin
      check("done_timeout0", 32'd0, 32'd1);
      return;
    end
    @(negedge clk);
    check("done_pulse0", 32'(bus0.done), 32'd0);
    check("idle_busy0", 32'(bus0.busy), 32'd0);
    check("idle_stim0", 32'(bus0.stim), 32'd0);
    check("hold_err0", 32'(bus0.err_count), 32'(e.err));
    check("hold_pass0", 32'(bus0.pass), 32'(e.pass));
    @(negedge clk);
    check("no_restart0", 32'(bus0.busy), 32'd0);
  endtask

  task automatic run1_back_to_back();
    int   runs = 0;
    int   busy_n = 0;
    int   idle_gap = -1;
    exp_t e;
    mode1 = 0;
    sb.push_back(model(0, 1));
    sb.push_back(model(0, 1));
    @(negedge clk) bus1.start = 1'b1;
    for (int c = 0; c < 100 && runs < 2; c++) begin
      @(negedge clk);
      if (bus1.busy) begin
        check("stim_seq1", 32'(bus1.stim), 32'(busy_n));
        busy_n++;
        if (idle_gap >= 0) begin
          check("idle_gap1", 32'(idle_gap), 32'd1);
          idle_gap = -1;
        end
      end else if (bus1.done) begin
        if (sb.size() == 0) begin
          check("sb_empty1", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("busy_len1", 32'(busy_n), 32'(e.busy_len));
          check("err_count1", 32'(bus1.err_count), 32'(e.err));
          check("pass1", 32'(bus1.pass), 32'(e.pass));
        end
        runs++;
        busy_n = 0;
        idle_gap = 0;
      end else if (idle_gap >= 0) begin
        idle_gap++;
      end
    end
    if (runs < 2) check("done_timeout1", 32'(runs), 32'd2);
    bus1.start = 1'b0;
    repeat (30) @(negedge clk);
  endtask

  initial begin
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    repeat (3) @(negedge clk);
    check_zero0("reset");
    check("reset_busy1", 32'(bus1.busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run0(0, 0, 0);
    run0(1, 0, 0);
    run0(2, 0, 0);
    run0(3, 0, 0);
    run0(0, 1, 0);
    run0(1, 0, 1);
    run0(0, 0, 0);
    run1_back_to_back();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
